// File: rtl/axi_ar_arbiter.sv
// -----------------------------------------------------------------------------
// axi_ar_arbiter
//
// Read-address-channel arbiter that shares one slave-side AR channel between
// three masters (M0 CPU-IF, M1 CPU-MEM, M2 DMA). One master is granted and its
// AR beat is forwarded with the master index prepended to the ID. The grant is
// held until the RLAST handshake of that burst completes, so only one read is
// ever outstanding.
//
// Configuration macro: AXI_AR_ARB_RR_EN
//   defined   - round-robin. The search starts at the master after the last one
//               served. The pointer only moves when a burst completes.
//   undefined - fixed priority M0 > M1 > M2. No pointer is kept.
//
// Parameters
//   ADDR_W  address width
//   IDM_W   master-side ID width
//   IDS_W   slave-side ID width. The upper IDS_W-IDM_W bits carry the master index.
//
// Ports
//   ACLK, ARESETn                    clock, asynchronous active-low reset
//   AR*_M0/M1/M2  (in)               master AR channels (ID, ADDR, LEN, SIZE,
//                                    BURST, VALID)
//   ARREADY_M0/M1/M2 (out)           AR accept, returned to each master
//   AR*_S (out), ARREADY_S (in)      slave-side AR channel toward the decoder
//   RVALID_S, RREADY_S, RLAST_S (in) R channel, observed for burst completion
//   GRANT (out)                      one-hot current owner (0 = none)
// -----------------------------------------------------------------------------
module axi_ar_arbiter #(
    parameter int ADDR_W = 32,
    parameter int IDM_W  = 4,
    parameter int IDS_W  = 8
) (
    input  logic              ACLK,
    input  logic              ARESETn,

    input  logic [IDM_W-1:0]  ARID_M0,
    input  logic [ADDR_W-1:0] ARADDR_M0,
    input  logic [3:0]        ARLEN_M0,
    input  logic [2:0]        ARSIZE_M0,
    input  logic [1:0]        ARBURST_M0,
    input  logic              ARVALID_M0,
    output logic              ARREADY_M0,

    input  logic [IDM_W-1:0]  ARID_M1,
    input  logic [ADDR_W-1:0] ARADDR_M1,
    input  logic [3:0]        ARLEN_M1,
    input  logic [2:0]        ARSIZE_M1,
    input  logic [1:0]        ARBURST_M1,
    input  logic              ARVALID_M1,
    output logic              ARREADY_M1,

    input  logic [IDM_W-1:0]  ARID_M2,
    input  logic [ADDR_W-1:0] ARADDR_M2,
    input  logic [3:0]        ARLEN_M2,
    input  logic [2:0]        ARSIZE_M2,
    input  logic [1:0]        ARBURST_M2,
    input  logic              ARVALID_M2,
    output logic              ARREADY_M2,

    output logic [IDS_W-1:0]  ARID_S,
    output logic [ADDR_W-1:0] ARADDR_S,
    output logic [3:0]        ARLEN_S,
    output logic [2:0]        ARSIZE_S,
    output logic [1:0]        ARBURST_S,
    output logic              ARVALID_S,
    input  logic              ARREADY_S,

    input  logic              RVALID_S,
    input  logic              RREADY_S,
    input  logic              RLAST_S,

    output logic [2:0]        GRANT
);

    localparam int NM    = 3;
    localparam int TAG_W = IDS_W - IDM_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t            state_reg;
    logic [NM-1:0]     grant_reg;

    // Master-side fields gathered into arrays so the mux can be written once.
    logic [IDM_W-1:0]  id_m    [NM];
    logic [ADDR_W-1:0] addr_m  [NM];
    logic [3:0]        len_m   [NM];
    logic [2:0]        size_m  [NM];
    logic [1:0]        burst_m [NM];
    logic [NM-1:0]     req;
    logic [NM-1:0]     ready_m;

    logic [NM-1:0]     pick_next;   // winner of the arbitration in IDLE
    logic              sel_valid;   // ARVALID of the granted master
    logic              r_last_hs;   // final R beat handshake

    logic [IDM_W-1:0]  id_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [3:0]        len_mux;
    logic [2:0]        size_mux;
    logic [1:0]        burst_mux;
    logic [1:0]        owner_idx;

    assign id_m[0]    = ARID_M0;
    assign id_m[1]    = ARID_M1;
    assign id_m[2]    = ARID_M2;
    assign addr_m[0]  = ARADDR_M0;
    assign addr_m[1]  = ARADDR_M1;
    assign addr_m[2]  = ARADDR_M2;
    assign len_m[0]   = ARLEN_M0;
    assign len_m[1]   = ARLEN_M1;
    assign len_m[2]   = ARLEN_M2;
    assign size_m[0]  = ARSIZE_M0;
    assign size_m[1]  = ARSIZE_M1;
    assign size_m[2]  = ARSIZE_M2;
    assign burst_m[0] = ARBURST_M0;
    assign burst_m[1] = ARBURST_M1;
    assign burst_m[2] = ARBURST_M2;

    assign req = {ARVALID_M2, ARVALID_M1, ARVALID_M0};

    assign sel_valid = |(grant_reg & req);
    assign r_last_hs = RVALID_S && RREADY_S && RLAST_S;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef AXI_AR_ARB_RR_EN
    logic [1:0] ptr_reg;    // master searched first in the next arbitration
    logic [1:0] ptr_next;   // master after the current owner

    always_comb begin
        ptr_next = 2'd0;
        case (grant_reg)
            3'b001:  ptr_next = 2'd1;
            3'b010:  ptr_next = 2'd2;
            default: ptr_next = 2'd0;
        endcase
    end

    always_comb begin
        pick_next = '0;
        case (ptr_reg)
            2'd1: begin
                if (req[1])      pick_next = 3'b010;
                else if (req[2]) pick_next = 3'b100;
                else if (req[0]) pick_next = 3'b001;
            end
            2'd2: begin
                if (req[2])      pick_next = 3'b100;
                else if (req[0]) pick_next = 3'b001;
                else if (req[1]) pick_next = 3'b010;
            end
            default: begin
                if (req[0])      pick_next = 3'b001;
                else if (req[1]) pick_next = 3'b010;
                else if (req[2]) pick_next = 3'b100;
            end
        endcase
    end
`else
    always_comb begin
        pick_next = '0;
        if (req[0])      pick_next = 3'b001;
        else if (req[1]) pick_next = 3'b010;
        else if (req[2]) pick_next = 3'b100;
    end
`endif

    // -------------------------------------------------------------------------
    // Control FSM: IDLE -> ADDR -> DATA -> IDLE. GRANT is held from the
    // arbitration edge until the burst finishes or the master withdraws.
    // -------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
`ifdef AXI_AR_ARB_RR_EN
            ptr_reg   <= 2'd0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        grant_reg <= pick_next;
                        state_reg <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // A master that withdraws ARVALID before the handshake
                    // loses its grant. The pointer is left alone because
                    // nothing was served.
                    if (!sel_valid) begin
                        grant_reg <= '0;
                        state_reg <= ST_IDLE;
                    end else if (ARREADY_S) begin
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_last_hs) begin
                        grant_reg <= '0;
                        state_reg <= ST_IDLE;
`ifdef AXI_AR_ARB_RR_EN
                        ptr_reg   <= ptr_next;
`endif
                    end
                end
                default: begin
                    grant_reg <= '0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Per-master ARREADY: only the granted master sees the decoder READY, and
    // only while its address beat is being offered.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NM; gi++) begin : g_ready
            assign ready_m[gi] = (state_reg == ST_ADDR) && grant_reg[gi] && ARREADY_S;
        end
    endgenerate

    assign ARREADY_M0 = ready_m[0];
    assign ARREADY_M1 = ready_m[1];
    assign ARREADY_M2 = ready_m[2];

    // -------------------------------------------------------------------------
    // AND-OR field mux on the one-hot grant. With no grant, every field
    // (including the tag) is zero.
    // -------------------------------------------------------------------------
    always_comb begin
        id_mux    = '0;
        addr_mux  = '0;
        len_mux   = '0;
        size_mux  = '0;
        burst_mux = '0;
        owner_idx = 2'd0;
        for (int i = 0; i < NM; i++) begin
            id_mux    = id_mux    | (id_m[i]    & {IDM_W{grant_reg[i]}});
            addr_mux  = addr_mux  | (addr_m[i]  & {ADDR_W{grant_reg[i]}});
            len_mux   = len_mux   | (len_m[i]   & {4{grant_reg[i]}});
            size_mux  = size_mux  | (size_m[i]  & {3{grant_reg[i]}});
            burst_mux = burst_mux | (burst_m[i] & {2{grant_reg[i]}});
            if (grant_reg[i]) begin
                owner_idx = 2'(i);
            end
        end
    end

    assign ARID_S    = {TAG_W'(owner_idx), id_mux};
    assign ARADDR_S  = addr_mux;
    assign ARLEN_S   = len_mux;
    assign ARSIZE_S  = size_mux;
    assign ARBURST_S = burst_mux;

    // ARVALID follows the granted master directly, so a withdrawal is seen by
    // the decoder in the same cycle.
    assign ARVALID_S = (state_reg == ST_ADDR) && sel_valid;
    assign GRANT     = grant_reg;

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_ar_arbiter
//
// Self-checking bench for axi_ar_arbiter. A reference model tracks the
// current owner, whether its address beat was accepted, and where the next
// search starts. Every cycle the model predicts all DUT outputs. A vector table
// covers single, burst-hold and stall/withdraw sequences. Hand sequences cover
// contention ordering and reset during a burst. A randomized phase finishes
// the run.
// -----------------------------------------------------------------------------
module tb_axi_ar_arbiter;

    logic        ACLK;
    logic        ARESETn;
    logic [3:0]  ARID_M0, ARID_M1, ARID_M2;
    logic [31:0] ARADDR_M0, ARADDR_M1, ARADDR_M2;
    logic [3:0]  ARLEN_M0, ARLEN_M1, ARLEN_M2;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1, ARSIZE_M2;
    logic [1:0]  ARBURST_M0, ARBURST_M1, ARBURST_M2;
    logic        ARVALID_M0, ARVALID_M1, ARVALID_M2;
    logic        ARREADY_M0, ARREADY_M1, ARREADY_M2;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S;
    logic        RVALID_S, RREADY_S, RLAST_S;
    logic [2:0]  GRANT;

    // Stimulus storage for the master side.
    logic [3:0]  id_in    [3];
    logic [31:0] addr_in  [3];
    logic [3:0]  len_in   [3];
    logic [2:0]  size_in  [3];
    logic [1:0]  burst_in [3];
    logic [2:0]  v_in;

    assign ARID_M0 = id_in[0];      assign ARID_M1 = id_in[1];      assign ARID_M2 = id_in[2];
    assign ARADDR_M0 = addr_in[0];  assign ARADDR_M1 = addr_in[1];  assign ARADDR_M2 = addr_in[2];
    assign ARLEN_M0 = len_in[0];    assign ARLEN_M1 = len_in[1];    assign ARLEN_M2 = len_in[2];
    assign ARSIZE_M0 = size_in[0];  assign ARSIZE_M1 = size_in[1];  assign ARSIZE_M2 = size_in[2];
    assign ARBURST_M0 = burst_in[0]; assign ARBURST_M1 = burst_in[1]; assign ARBURST_M2 = burst_in[2];
    assign ARVALID_M0 = v_in[0];    assign ARVALID_M1 = v_in[1];    assign ARVALID_M2 = v_in[2];

    axi_ar_arbiter dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
        .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
        .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .ARID_M2(ARID_M2), .ARADDR_M2(ARADDR_M2), .ARLEN_M2(ARLEN_M2), .ARSIZE_M2(ARSIZE_M2),
        .ARBURST_M2(ARBURST_M2), .ARVALID_M2(ARVALID_M2), .ARREADY_M2(ARREADY_M2),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S), .RLAST_S(RLAST_S),
        .GRANT(GRANT)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_err    = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    int m_owner;      // -1 = nobody holds the channel
    bit m_ar_done;    // owner's address beat already accepted
    int m_start;      // first master searched in the next arbitration

    function automatic void mdl_reset();
        m_owner   = -1;
        m_ar_done = 1'b0;
        m_start   = 0;
    endfunction

    function automatic int mdl_pick(logic [2:0] v);
        for (int k = 0; k < 3; k++) begin
            int m;
`ifdef AXI_AR_ARB_RR_EN
            m = (m_start + k) % 3;
`else
            m = k;
`endif
            if (v[m]) return m;
        end
        return -1;
    endfunction

    function automatic void mdl_step();
        if (m_owner < 0) begin
            m_owner   = mdl_pick(v_in);
            m_ar_done = 1'b0;
        end else if (!m_ar_done) begin
            if (!v_in[m_owner])  m_owner = -1;
            else if (ARREADY_S)  m_ar_done = 1'b1;
        end else if (RVALID_S && RREADY_S && RLAST_S) begin
            m_start = (m_owner + 1) % 3;
            m_owner = -1;
        end
    endfunction

    logic       arhs_last;
    logic [2:0] grant_last;

    function automatic void check_model();
        logic [2:0]  e_grant, e_ardy;
        logic        e_arvs;
        logic [7:0]  e_arid;
        logic [31:0] e_addr;
        logic [3:0]  e_len;
        logic [2:0]  e_size;
        logic [1:0]  e_burst;
        e_grant = '0; e_ardy = '0; e_arvs = 1'b0; e_arid = '0;
        e_addr = '0; e_len = '0; e_size = '0; e_burst = '0;
        if (m_owner >= 0) begin
            e_grant = 3'(1 << m_owner);
            e_arid  = 8'(m_owner * 16) | 8'(id_in[m_owner]);
            e_addr  = addr_in[m_owner];
            e_len   = len_in[m_owner];
            e_size  = size_in[m_owner];
            e_burst = burst_in[m_owner];
            if (!m_ar_done) begin
                e_arvs = v_in[m_owner];
                e_ardy = ARREADY_S ? e_grant : 3'b000;
            end
        end
        chk("grant", GRANT, e_grant);
        chk("arvalid_s", ARVALID_S, e_arvs);
        chk("arready_m", {ARREADY_M2, ARREADY_M1, ARREADY_M0}, e_ardy);
        chk("arid_s", ARID_S, e_arid);
        chk("araddr_s", ARADDR_S, e_addr);
        chk("arlen_s", ARLEN_S, e_len);
        chk("arsize_s", ARSIZE_S, e_size);
        chk("arburst_s", ARBURST_S, e_burst);
    endfunction

    // One clock cycle: settle, compare against the model, clock, advance model.
    task automatic cycle();
        #2;
        if (!ARESETn) mdl_reset();
        check_model();
        arhs_last  = ARVALID_S && ARREADY_S;
        grant_last = GRANT;
        @(posedge ACLK);
        if (ARESETn) mdl_step();
        #1;
    endtask

    // Offer ARREADY_S until an AR handshake, then finish the burst with a
    // single RLAST beat. drop clears the served master's valid; add raises others.
    task automatic serve(input bit drop, input logic [2:0] add, output int who);
        int n;
        who = -1;
        ARREADY_S = 1'b1; RVALID_S = 1'b0; RLAST_S = 1'b0; RREADY_S = 1'b1;
        arhs_last = 1'b0;
        for (n = 0; n < 10; n++) begin
            cycle();
            if (arhs_last) break;
        end
        chk("serve_handshake_seen", arhs_last, 1'b1);
        case (grant_last)
            3'b001:  who = 0;
            3'b010:  who = 1;
            3'b100:  who = 2;
            default: who = -1;
        endcase
        if (drop && who >= 0) v_in[who] = 1'b0;
        v_in = v_in | add;
        ARREADY_S = 1'b0; RVALID_S = 1'b1; RLAST_S = 1'b1;
        cycle();
        RVALID_S = 1'b0; RLAST_S = 1'b0;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        cycle();
        ARESETn = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] v;
        logic       ardy, rv, rr, rl;
        logic [2:0] e_grant;
        logic       e_arvs;
        logic [2:0] e_ardy;
        logic [7:0] e_arid;
    } vec_t;

    vec_t tq[$];

    task automatic addv(input logic [2:0] v, input logic ardy, input logic rv, input logic rr,
                        input logic rl, input logic [2:0] eg, input logic ea,
                        input logic [2:0] er, input logic [7:0] eid);
        vec_t x;
        x.v = v; x.ardy = ardy; x.rv = rv; x.rr = rr; x.rl = rl;
        x.e_grant = eg; x.e_arvs = ea; x.e_ardy = er; x.e_arid = eid;
        tq.push_back(x);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int who;
        int exp3 [4];
        int exp4 [6];
        ARESETn = 1'b0; v_in = 3'b000;
        ARREADY_S = 1'b0; RVALID_S = 1'b0; RREADY_S = 1'b1; RLAST_S = 1'b0;
        id_in[0] = 4'h1; addr_in[0] = 32'h1000_0000; len_in[0] = 4'd0; size_in[0] = 3'd2; burst_in[0] = 2'd1;
        id_in[1] = 4'h3; addr_in[1] = 32'h0002_0010; len_in[1] = 4'd0; size_in[1] = 3'd2; burst_in[1] = 2'd1;
        id_in[2] = 4'h5; addr_in[2] = 32'h2000_0040; len_in[2] = 4'd3; size_in[2] = 3'd2; burst_in[2] = 2'd1;
        mdl_reset();
        @(posedge ACLK); #1;

        // Reset held with M1 requesting: nothing may be granted.
        v_in = 3'b010;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_grant", GRANT, 3'b000);
            chk("rst_arvalid_s", ARVALID_S, 1'b0);
            chk("rst_arready_m", {ARREADY_M2, ARREADY_M1, ARREADY_M0}, 3'b000);
        end
        ARESETn = 1'b1;

        //    v      ardy  rv    rr    rl     grant  arvs  ardy_m  arid
        // single-beat read by M1
        addv(3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 8'h00);
        addv(3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 3'b000, 8'h13);
        addv(3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 3'b010, 8'h13);
        addv(3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0, 3'b000, 8'h13);
        addv(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 8'h00);
        // M2 4-beat burst, M0 waits through DATA
        addv(3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 8'h00);
        addv(3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 3'b100, 8'h25);
        addv(3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 1'b0, 3'b000, 8'h25);
        addv(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 3'b000, 8'h25);
        addv(3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 1'b0, 3'b000, 8'h25);
        addv(3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 1'b0, 3'b000, 8'h25);
        addv(3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 3'b000, 8'h25);
        addv(3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0, 3'b000, 8'h25);
        addv(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 8'h00);
        // M0 stalled 5 cycles, then withdraws ARVALID
        for (int i = 0; i < 5; i++)
            addv(3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 3'b000, 8'h01);
        addv(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 3'b000, 8'h01);
        addv(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 8'h00);

        foreach (tq[i]) begin
            v_in = tq[i].v; ARREADY_S = tq[i].ardy;
            RVALID_S = tq[i].rv; RREADY_S = tq[i].rr; RLAST_S = tq[i].rl;
            #2;
            chk($sformatf("vec%0d_grant", i), GRANT, tq[i].e_grant);
            chk($sformatf("vec%0d_arvalid_s", i), ARVALID_S, tq[i].e_arvs);
            chk($sformatf("vec%0d_arready_m", i), {ARREADY_M2, ARREADY_M1, ARREADY_M0}, tq[i].e_ardy);
            chk($sformatf("vec%0d_arid_s", i), ARID_S, tq[i].e_arid);
            cycle();
        end
        RVALID_S = 1'b0; RLAST_S = 1'b0; RREADY_S = 1'b1; ARREADY_S = 1'b0;

        // Contention with M0 re-requesting while M2 waits.
`ifdef AXI_AR_ARB_RR_EN
        exp3 = '{0, 1, 2, 0};
        exp4 = '{0, 1, 2, 0, 1, 2};
`else
        exp3 = '{0, 1, 0, 2};
        exp4 = '{0, 0, 0, 0, 0, 0};
`endif
        do_reset();
        v_in = 3'b111;
        serve(1'b1, 3'b000, who); chk("order3_0", who, exp3[0]);
        serve(1'b1, 3'b001, who); chk("order3_1", who, exp3[1]);
        serve(1'b1, 3'b000, who); chk("order3_2", who, exp3[2]);
        serve(1'b1, 3'b000, who); chk("order3_3", who, exp3[3]);

        // All three held valid for six bursts.
        do_reset();
        v_in = 3'b111;
        for (int k = 0; k < 6; k++) begin
            serve(1'b0, 3'b000, who);
            chk($sformatf("order4_%0d", k), who, exp4[k]);
        end
        v_in = 3'b000;
        cycle(); cycle();

        // Reset during DATA abandons the burst and returns the pointer to M0.
        do_reset();
        v_in = 3'b001;
        serve(1'b1, 3'b000, who); chk("rstdata_first", who, 0);
        v_in = 3'b010; ARREADY_S = 1'b1;
        cycle(); cycle();
        ARREADY_S = 1'b0; ARESETn = 1'b0;
        cycle();
        chk("rstdata_grant", GRANT, 3'b000);
        ARESETn = 1'b1;
        v_in = 3'b111;
        serve(1'b1, 3'b000, who); chk("rstdata_after", who, 0);
        v_in = 3'b000;
        cycle();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 3; m++) begin
                if (v_in[m] && arhs_last && grant_last[m]) begin
                    v_in[m] = 1'b0;
                end else if (!v_in[m]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        v_in[m]     = 1'b1;
                        id_in[m]    = 4'($urandom);
                        addr_in[m]  = $urandom;
                        len_in[m]   = 4'($urandom);
                        size_in[m]  = 3'($urandom);
                        burst_in[m] = 2'($urandom);
                    end
                end else if ($urandom_range(0, 29) == 0) begin
                    v_in[m] = 1'b0;
                end
            end
            ARREADY_S = 1'($urandom_range(0, 1));
            RVALID_S  = 1'($urandom_range(0, 1));
            RREADY_S  = ($urandom_range(0, 3) != 0);
            RLAST_S   = ($urandom_range(0, 2) == 0);
            ARESETn   = ($urandom_range(0, 299) != 0);
            cycle();
        end
        ARESETn = 1'b1;
        v_in = 3'b000;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
